dmem_responder: RTL and testbench

- Data-memory responder for the NPC core. It services the load and store requests raised when the control unit asserts load / en_Wmem.
- Accepts one request at a time over a valid/ready channel and applies a programmable wait latency.
- Performs byte/half/word access with RISC-V funct3 sizing and sign extension, then returns a response over a second valid/ready channel.
- Sits between the core's memory stage and a word-organised internal RAM.

---
 rtl/dmem_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the NPC core: one request at a time over a
// valid/ready channel, a fixed wait latency, RISC-V sized load/store into
// a word-organised internal RAM, and a response over a second valid/ready
// channel.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic            fire;
  logic            enter_resp;
  logic            mem_we;
  logic            cur_wen;
  logic [2:0]      cur_f3;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [31:0]     off;
  logic            acc_err;
  logic [IDXW-1:0] widx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [31:0]     ld_data;
  logic [3:0]      be;
  logic [31:0]     wd_rep;
  logic [31:0]     wr_word;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign fire = req_valid && req_ready_q;

  // With zero latency the access is evaluated on the accept edge itself,
  // so the live request fields stand in for the not-yet-latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_wen   = req_wen;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_wen   = wen_q;
      cur_f3    = funct3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  // Address decode and fault detection for the access being completed.
  always_comb begin
    off     = cur_addr - BASE;
    widx    = off[IDXW+1:2];
    lane    = cur_addr[1:0];
    acc_err = 1'b0;
    if (cur_wen) begin
      if (!(cur_f3 inside {3'b000, 3'b001, 3'b010})) acc_err = 1'b1;
    end else begin
      if (!(cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) acc_err = 1'b1;
    end
    if (cur_f3[1:0] == 2'b01 && cur_addr[0])          acc_err = 1'b1;
    if (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) acc_err = 1'b1;
    if (cur_addr < BASE)                              acc_err = 1'b1;
    if ({1'b0, off} >= SPAN)                          acc_err = 1'b1;
  end

  assign rd_word = mem[widx];

  // Load lane selection and sign/zero extension.
  always_comb begin
    rd_shift = rd_word >> {lane, 3'b000};
    case (cur_f3)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = '0;
    endcase
  end

  // Store byte-strobe generation and merge into the existing word.
  always_comb begin
    case (cur_f3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = 4'b0011 << lane;
        wd_rep = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = cur_wdata;
      end
    endcase
    wr_word = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  // Next-state and registered-output computation for the request FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wen_d        = wen_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    enter_resp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          wen_d       = req_wen;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
    if (enter_resp) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (cur_wen || acc_err) ? '0 : ld_data;
    end
  end

  assign mem_we = enter_resp && cur_wen && !acc_err;

  // FSM state, wait counter, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wen_q        <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wen_q        <= wen_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Internal RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with
// LATENCY=2 and one with LATENCY=0, selected by sel_b.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, b_req_ready;
  logic        a_resp_valid, b_resp_valid;
  logic [31:0] a_resp_rdata, b_resp_rdata;
  logic        a_resp_err, b_resp_err;

  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid && !sel_b;
  assign b_req_valid = req_valid && sel_b;

  always_comb begin
    o_req_ready  = a_req_ready;
    o_resp_valid = a_resp_valid;
    o_resp_rdata = a_resp_rdata;
    o_resp_err   = a_resp_err;
    if (sel_b) begin
      o_req_ready  = b_req_ready;
      o_resp_valid = b_resp_valid;
      o_resp_rdata = b_resp_rdata;
      o_resp_err   = b_resp_err;
    end
  end

  dmem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Full transaction; cyc counts cycles from the acceptance cycle (=1)
  // to the first cycle with resp_valid high. Called just after a posedge.
  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int cyc);
    int n = 0;
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b0;
    while (!o_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!o_resp_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!o_resp_valid) begin
      $display("FAIL timeout addr=%h got no resp_valid exp resp_valid=1", addr);
      rdata = 'x; err = 1'bx;
    end else begin
      rdata = o_resp_rdata; err = o_resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", o_req_ready); end
    tests++; if (o_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b exp 0", o_resp_valid); end
    tests++; if (o_resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", o_resp_rdata); end
    tests++; if (o_resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", o_resp_err); end
  endtask

  task automatic test_sw_lw();
    logic [31:0] d; logic e; int c;
    issue(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sw_resp got %h/%b exp 0/0", d, e); end
    tests++; if (c !== 3) begin fails++; $display("FAIL sw_latency got %0d exp 3", c); end
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin fails++; $display("FAIL lw_data got %h/%b exp deadbeef/0", d, e); end
    tests++; if (c !== 3) begin fails++; $display("FAIL lw_latency got %0d exp 3", c); end
  endtask

  task automatic test_extension();
    logic [31:0] d; logic e; int c;
    issue(1'b0, 3'b000, 32'h8000_0013, 32'h0, d, e, c);
    tests++; if (d !== 32'hFFFF_FFDE || e !== 1'b0) begin fails++; $display("FAIL lb got %h/%b exp ffffffde/0", d, e); end
    issue(1'b0, 3'b100, 32'h8000_0013, 32'h0, d, e, c);
    tests++; if (d !== 32'h0000_00DE || e !== 1'b0) begin fails++; $display("FAIL lbu got %h/%b exp 000000de/0", d, e); end
    issue(1'b0, 3'b001, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'hFFFF_BEEF || e !== 1'b0) begin fails++; $display("FAIL lh got %h/%b exp ffffbeef/0", d, e); end
    issue(1'b0, 3'b101, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'h0000_BEEF || e !== 1'b0) begin fails++; $display("FAIL lhu got %h/%b exp 0000beef/0", d, e); end
    issue(1'b0, 3'b101, 32'h8000_0012, 32'h0, d, e, c);
    tests++; if (d !== 32'h0000_DEAD || e !== 1'b0) begin fails++; $display("FAIL lhu_upper got %h/%b exp 0000dead/0", d, e); end
  endtask

  task automatic test_partial_store();
    logic [31:0] d; logic e; int c;
    issue(1'b1, 3'b000, 32'h8000_0011, 32'hFFFF_FF12, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sb_resp got %h/%b exp 0/0", d, e); end
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'hDEAD_12EF) begin fails++; $display("FAIL sb_merge got %h exp dead12ef", d); end
    issue(1'b1, 3'b001, 32'h8000_001A, 32'hAAAA_5678, d, e, c);
    issue(1'b1, 3'b001, 32'h8000_0018, 32'hBBBB_1234, d, e, c);
    issue(1'b0, 3'b010, 32'h8000_0018, 32'h0, d, e, c);
    tests++; if (d !== 32'h5678_1234) begin fails++; $display("FAIL sh_merge got %h exp 56781234", d); end
  endtask

  task automatic test_faults();
    logic [31:0] d; logic e; int c;
    issue(1'b0, 3'b010, 32'h8000_0012, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lw_misalign got %h/%b exp 0/1", d, e); end
    issue(1'b0, 3'b001, 32'h8000_0011, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lh_misalign got %h/%b exp 0/1", d, e); end
    issue(1'b1, 3'b100, 32'h8000_0010, 32'h1111_1111, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL st_f3_100 got %h/%b exp 0/1", d, e); end
    issue(1'b0, 3'b011, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL ld_f3_011 got %h/%b exp 0/1", d, e); end
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, d, e, c);
    tests++; if (d !== 32'hDEAD_12EF) begin fails++; $display("FAIL bad_store_nowrite got %h exp dead12ef", d); end
    issue(1'b0, 3'b010, 32'h8000_1000, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lw_past_end got %h/%b exp 0/1", d, e); end
    issue(1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lw_below_base got %h/%b exp 0/1", d, e); end
    issue(1'b1, 3'b010, 32'h8000_0FFC, 32'hCAFE_0001, d, e, c);
    issue(1'b0, 3'b010, 32'h8000_0FFC, 32'h0, d, e, c);
    tests++; if (d !== 32'hCAFE_0001 || e !== 1'b0) begin fails++; $display("FAIL last_word got %h/%b exp cafe0001/0", d, e); end
    issue(1'b1, 3'b010, 32'h8000_0014, 32'h1122_3344, d, e, c);
    issue(1'b1, 3'b010, 32'h8000_0016, 32'hCAFE_F00D, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL sw_misalign got %h/%b exp 0/1", d, e); end
    issue(1'b0, 3'b010, 32'h8000_0014, 32'h0, d, e, c);
    tests++; if (d !== 32'h1122_3344 || e !== 1'b0) begin fails++; $display("FAIL sw_misalign_nowrite got %h/%b exp 11223344/0", d, e); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 32'h8000_0014;
    while (!o_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      tests++; if (o_resp_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b exp 1", i, o_resp_valid); end
      tests++; if (o_resp_rdata !== 32'hDEAD_12EF) begin fails++; $display("FAIL stall_rdata[%0d] got %h exp dead12ef", i, o_resp_rdata); end
      tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL stall_req_ready[%0d] got %b exp 0", i, o_req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tests++; if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin fails++; $display("FAIL post_hs got ready=%b valid=%b exp 1/0", o_req_ready, o_resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL second_accept got req_ready=%b exp 0", o_req_ready); end
    n = 0;
    while (!o_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++; if (o_resp_rdata !== 32'h1122_3344 || o_resp_valid !== 1'b1) begin fails++; $display("FAIL second_data got %h/%b exp 11223344/1", o_resp_rdata, o_resp_valid); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int c;
    issue(1'b1, 3'b010, 32'h8000_0020, 32'h0, d, e, c);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0020; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_resp_rdata !== 32'h0 || o_resp_err !== 1'b0) begin
      fails++; $display("FAIL midwait_reset got rdy=%b vld=%b d=%h e=%b exp 1/0/0/0", o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, d, e, c);
    tests++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL dropped_store got %h/%b exp 0/0", d, e); end
  endtask

  task automatic test_latency0();
    logic [31:0] d; logic e; int c;
    sel_b = 1'b1;
    issue(1'b1, 3'b010, 32'h8000_0020, 32'h0, d, e, c);
    tests++; if (c !== 1) begin fails++; $display("FAIL lat0_latency got %0d exp 1", c); end
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0020; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (o_resp_valid !== 1'b1 || o_resp_err !== 1'b0) begin fails++; $display("FAIL lat0_resp got %b/%b exp 1/0", o_resp_valid, o_resp_err); end
    rst_n = 1'b0;
    #1;
    tests++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin fails++; $display("FAIL lat0_reset got vld=%b rdy=%b exp 0/1", o_resp_valid, o_req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, d, e, c);
    tests++; if (d !== 32'h55 || e !== 1'b0) begin fails++; $display("FAIL lat0_persist got %h/%b exp 00000055/0", d, e); end
    issue(1'b0, 3'b000, 32'h8000_0020, 32'h0, d, e, c);
    tests++; if (d !== 32'h55 || c !== 1) begin fails++; $display("FAIL lat0_lb got %h lat %0d exp 00000055 lat 1", d, c); end
    sel_b = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sw_lw();
    test_extension();
    test_partial_store();
    test_faults();
    test_backpressure();
    test_reset_mid_wait();
    test_latency0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
